// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses InstructionMemory and buffers
// fetched (pc, instr) pairs in a small FIFO for decode, with redirect flushing.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          DEPTH_LOG2 = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(FIFO_DEPTH);

    state_e                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [31:0]           instrBuf_q [FIFO_DEPTH];
    logic [31:0]           pcBuf_q    [FIFO_DEPTH];

    logic push;
    logic pop;
    logic notEmpty;

    assign notEmpty = (count_q != '0);
    assign pop      = notEmpty & out_ready & ~redirect_valid;
    assign push     = (state_q == RUN) & ~redirect_valid & ((count_q != DEPTH_C) | pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (redirect_valid) begin
            // Redirect wins over everything: flush the buffer and restart fetch at the target.
            state_d = RUN;
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            count_d = '0;
            rdPtr_d = '0;
            wrPtr_d = '0;
        end else begin
            state_d = RUN;
            if (push) begin
                pc_d    = pc_q + 32'd4;
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            count_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
        end
    end

    // Buffer contents need no reset: they are masked by an empty count.
    always_ff @(posedge clk) begin
        if (push) begin
            instrBuf_q[wrPtr_q] <= imem_instr;
            pcBuf_q[wrPtr_q]    <= pc_q;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = notEmpty;
    assign out_instr = notEmpty ? instrBuf_q[rdPtr_q] : 32'h0;
    assign out_pc    = notEmpty ? pcBuf_q[rdPtr_q]    : 32'h0;

endmodule
